// File: rtl/spi_master_frame.sv
// -----------------------------------------------------------------------------
// spi_master_frame
//
// SPI master that clocks one fixed-length, full-duplex frame to an SPI slave
// frame endpoint. The protocol matches the endpoint:
//   - SPI_CS is active low and SPI_CLK idles low.
//   - Bit 0 is sent and received first.
//   - SPI_MOSI changes on the SCK falling edge and the slave samples it on the
//     rising edge.
//   - SPI_MISO is sampled in the last CLK cycle of each SCK high phase, just
//     before the fall. By then the slave (with its 5-cycle input filters) has
//     settled the bit it drove after the previous fall or after CS fell.
// Every output comes straight from a flop.
//
// Parameters
//   FRAME_BITS  bits per frame
//   CLK_DIV     CLK cycles per SCK half-period (at least 8 with a 5-cycle
//               slave filter)
//   CS_SETUP    CLK cycles from CS low to the first SCK rising edge
//   CS_HOLD     CLK cycles from the last SCK falling edge to CS high
//   CS_GAP      minimum CLK cycles CS stays high between frames
//
// Ports
//   CLK       in   system clock
//   RESET_N   in   synchronous, active-low reset
//   LOOPBACK  in   only with SPI_MASTER_LOOPBACK_EN: sample SPI_MOSI instead
//                  of SPI_MISO for this frame (latched when START is accepted)
//   START     in   frame request, honoured only in IDLE
//   DATA_TX   in   transmit frame, latched when START is accepted
//   SPI_MISO  in   serial data from the slave (already synchronised)
//   SPI_CS    out  chip select, active low
//   SPI_CLK   out  serial clock
//   SPI_MOSI  out  serial data to the slave
//   DATA_RX   out  last completed received frame
//   BUSY      out  high from the cycle after START acceptance until IDLE
//   DONE      out  one-cycle pulse when a frame completes
//
// Optional feature
//   Define SPI_MASTER_LOOPBACK_EN to add the LOOPBACK input. When LOOPBACK is
//   high at START acceptance, the receive path samples the internal SPI_MOSI
//   register, so DATA_RX returns the transmitted frame. The SPI pins still
//   toggle normally in loopback.
// -----------------------------------------------------------------------------
module spi_master_frame #(
   parameter int FRAME_BITS = 512,
   parameter int CLK_DIV    = 10,
   parameter int CS_SETUP   = 16,
   parameter int CS_HOLD    = 16,
   parameter int CS_GAP     = 16
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
`ifdef SPI_MASTER_LOOPBACK_EN
   input  logic                  LOOPBACK,
`endif
   input  logic                  START,
   input  logic [FRAME_BITS-1:0] DATA_TX,
   input  logic                  SPI_MISO,
   output logic                  SPI_CS,
   output logic                  SPI_CLK,
   output logic                  SPI_MOSI,
   output logic [FRAME_BITS-1:0] DATA_RX,
   output logic                  BUSY,
   output logic                  DONE
);

   // --------------------------------------------------------------------------
   // Counter sizing
   // --------------------------------------------------------------------------
   localparam int BIT_W   = $clog2(FRAME_BITS) + 1;
   localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int MAX_B   = (CS_HOLD > CS_GAP)   ? CS_HOLD : CS_GAP;
   localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   // Terminal values: each timed phase ends on the edge where the counter,
   // cleared on entry, reaches its length minus one.
   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SCK_HI,
      SCK_LO,
      HOLD,
      GAP
   } state_t;

   // --------------------------------------------------------------------------
   // State and next-state signals
   // --------------------------------------------------------------------------
   state_t                  state,   state_nxt;
   logic [CNT_W-1:0]        cnt,     cnt_nxt;
   logic [BIT_W-1:0]        bit_ctr, bit_ctr_nxt;
   logic [FRAME_BITS-1:0]   tx_sr,   tx_sr_nxt;
   logic [FRAME_BITS-1:0]   rx_sr,   rx_sr_nxt;
   logic [FRAME_BITS-1:0]   data_rx_nxt;
   logic                    cs_nxt;
   logic                    sck_nxt;
   logic                    mosi_nxt;
   logic                    busy_nxt;
   logic                    done_nxt;
   logic                    rx_bit;

   // Receive source. In loopback the bit is taken from the SPI_MOSI flop,
   // which holds tx bit bit_ctr for the whole SCK high phase.
`ifdef SPI_MASTER_LOOPBACK_EN
   logic loopback_q, loopback_nxt;
   assign rx_bit = loopback_q ? SPI_MOSI : SPI_MISO;
`else
   assign rx_bit = SPI_MISO;
`endif

   // --------------------------------------------------------------------------
   // Next-state and output logic
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default first, so no path can leave one
      // unassigned and infer a latch.
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_ctr_nxt = bit_ctr;
      tx_sr_nxt   = tx_sr;
      rx_sr_nxt   = rx_sr;
      data_rx_nxt = DATA_RX;
      cs_nxt      = SPI_CS;
      sck_nxt     = SPI_CLK;
      mosi_nxt    = SPI_MOSI;
      busy_nxt    = BUSY;
      done_nxt    = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
      loopback_nxt = loopback_q;
`endif

      unique case (state)
         IDLE: begin
            if (START) begin
               tx_sr_nxt   = DATA_TX;
               rx_sr_nxt   = '0;
               bit_ctr_nxt = '0;
               cnt_nxt     = '0;
               cs_nxt      = 1'b0;
               mosi_nxt    = DATA_TX[0];
               busy_nxt    = 1'b1;
               state_nxt   = SETUP;
`ifdef SPI_MASTER_LOOPBACK_EN
               loopback_nxt = LOOPBACK;
`endif
            end
         end

         SETUP: begin
            if (cnt == SETUP_LAST) begin
               cnt_nxt   = '0;
               sck_nxt   = 1'b1;
               state_nxt = SCK_HI;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         SCK_HI: begin
            if (cnt == DIV_LAST) begin
               cnt_nxt = '0;
               sck_nxt = 1'b0;
               // Shifting in from the top puts the first received bit at
               // index 0 once all FRAME_BITS have arrived.
               rx_sr_nxt = {rx_bit, rx_sr[FRAME_BITS-1:1]};
               if (bit_ctr == BIT_LAST) begin
                  // MOSI stays at the last bit through HOLD.
                  state_nxt = HOLD;
               end else begin
                  // tx_sr[0] is the bit now on MOSI; tx_sr[1] is the next one.
                  bit_ctr_nxt = bit_ctr + 1'b1;
                  tx_sr_nxt   = tx_sr >> 1;
                  mosi_nxt    = tx_sr[1];
                  state_nxt   = SCK_LO;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         SCK_LO: begin
            if (cnt == DIV_LAST) begin
               cnt_nxt   = '0;
               sck_nxt   = 1'b1;
               state_nxt = SCK_HI;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         HOLD: begin
            if (cnt == HOLD_LAST) begin
               cnt_nxt     = '0;
               cs_nxt      = 1'b1;
               mosi_nxt    = 1'b0;
               data_rx_nxt = rx_sr;
               done_nxt    = 1'b1;
               state_nxt   = GAP;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_nxt   = '0;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   // NOTE: non-blocking assignments only, so every flop takes the value from
   // before the edge no matter how the statements are ordered.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_ctr  <= '0;
         // NOTE: the frame-wide shift registers and DATA_RX are reset as
         // well. An aborted frame must leave DATA_RX at zero, not at a
         // partial frame.
         tx_sr    <= '0;
         rx_sr    <= '0;
         DATA_RX  <= '0;
         SPI_CS   <= 1'b1;
         SPI_CLK  <= 1'b0;
         SPI_MOSI <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
         loopback_q <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         bit_ctr  <= bit_ctr_nxt;
         tx_sr    <= tx_sr_nxt;
         rx_sr    <= rx_sr_nxt;
         DATA_RX  <= data_rx_nxt;
         SPI_CS   <= cs_nxt;
         SPI_CLK  <= sck_nxt;
         SPI_MOSI <= mosi_nxt;
         BUSY     <= busy_nxt;
         DONE     <= done_nxt;
`ifdef SPI_MASTER_LOOPBACK_EN
         loopback_q <= loopback_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_spi_master_frame.sv
// -----------------------------------------------------------------------------
// tb_spi_master_frame
//
// Self-checking bench for spi_master_frame with the default parameters. The
// bench contains a behavioural slave endpoint with 5-cycle input filters.
// Frame vectors come from a table; the multi-cycle corner cases are written
// out by hand: START while busy, START held high, reset mid-frame, and
// loopback when SPI_MASTER_LOOPBACK_EN is defined.
// -----------------------------------------------------------------------------
module tb_spi_master_frame;

   localparam int FB         = 512;
   localparam int CS_GAP     = 16;
   localparam int CS_LOW_EXP = 10262;   // 16 + 1023*10 + 16
   localparam int BUSY_EXP   = 10278;   // CS low time + CS_GAP
   localparam int BUDGET     = 12000;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [FB-1:0] data_tx = '0;
   logic          spi_miso;
   logic          spi_cs;
   logic          spi_clk;
   logic          spi_mosi;
   logic [FB-1:0] data_rx;
   logic          busy;
   logic          done;
   logic          miso_tie0 = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
   logic          loopback = 1'b0;
`endif

   always #5 clk = ~clk;

   spi_master_frame dut (
      .CLK      (clk),
      .RESET_N  (reset_n),
`ifdef SPI_MASTER_LOOPBACK_EN
      .LOOPBACK (loopback),
`endif
      .START    (start),
      .DATA_TX  (data_tx),
      .SPI_MISO (spi_miso),
      .SPI_CS   (spi_cs),
      .SPI_CLK  (spi_clk),
      .SPI_MOSI (spi_mosi),
      .DATA_RX  (data_rx),
      .BUSY     (busy),
      .DONE     (done)
   );

   // --------------------------------------------------------------------------
   // Slave endpoint model: 5-sample filters on CS, SCK and MOSI
   // --------------------------------------------------------------------------
   logic [4:0]    cs_h = '1, sck_h = '0, mosi_h = '0;
   logic          cs_f = 1'b1, sck_f = 1'b0, mosi_f = 1'b0;
   logic          cs_d = 1'b1, sck_d = 1'b0;
   logic [FB-1:0] s_tx = '0;
   logic [FB-1:0] s_rx = '0;
   int            s_idx = 0;
   logic          s_miso = 1'b0;

   assign spi_miso = miso_tie0 ? 1'b0 : s_miso;

   always @(posedge clk) begin
      cs_h   <= {cs_h[3:0], spi_cs};
      sck_h  <= {sck_h[3:0], spi_clk};
      mosi_h <= {mosi_h[3:0], spi_mosi};
      if (&cs_h) cs_f <= 1'b1; else if (~|cs_h) cs_f <= 1'b0;
      if (&sck_h) sck_f <= 1'b1; else if (~|sck_h) sck_f <= 1'b0;
      if (&mosi_h) mosi_f <= 1'b1; else if (~|mosi_h) mosi_f <= 1'b0;
   end

   always @(posedge clk) begin
      cs_d  <= cs_f;
      sck_d <= sck_f;
      if (cs_d && !cs_f) begin
         s_idx  <= 0;
         s_miso <= s_tx[0];
         s_rx   <= '0;
      end else if (!cs_f) begin
         if (!sck_d && sck_f && s_idx < FB) s_rx[s_idx] <= mosi_f;
         if (sck_d && !sck_f) begin
            s_idx <= s_idx + 1;
            if (s_idx < FB - 1) s_miso <= s_tx[s_idx + 1];
         end
      end
   end

   // --------------------------------------------------------------------------
   // Checking helpers
   // --------------------------------------------------------------------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Frame statistics gathered by run_frame
   int m_rises, m_falls, m_cs_low, m_busy, m_done_cnt, m_done_max;
   int m_mosi_err, m_edge_err, m_rx_unstable, m_timeout;

   // Issue a one-cycle START with tx and monitor the frame until BUSY drops.
   // DATA_TX is inverted right after acceptance to show the frame is latched.
   task automatic run_frame(input logic [FB-1:0] tx, input bit pulse_mid, input bit pulse_gap);
      logic          prev_sck, prev_cs, prev_mosi, exp_mosi;
      logic [FB-1:0] prev_rx;
      int            cyc, run, idx;
      bit            mid_done, gap_done;
      m_rises = 0; m_falls = 0; m_cs_low = 0; m_busy = 0; m_done_cnt = 0;
      m_done_max = 0; m_mosi_err = 0; m_edge_err = 0; m_rx_unstable = 0;
      m_timeout = 0;
      @(negedge clk);
      data_tx = tx;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      data_tx = ~tx;
      prev_sck = 1'b0; prev_cs = 1'b1; prev_mosi = 1'b0; prev_rx = data_rx;
      cyc = 0; run = 0; mid_done = 0; gap_done = 0;
      while (1) begin
         start = 1'b0;
         if (!spi_cs) m_cs_low++;
         if (busy) m_busy++;
         if (!prev_sck && spi_clk) m_rises++;
         if (prev_sck && !spi_clk) m_falls++;
         if (done) begin
            m_done_cnt++;
            run++;
            if (run > m_done_max) m_done_max = run;
         end else begin
            run = 0;
         end
         idx = (m_falls < FB) ? m_falls : FB - 1;
         exp_mosi = !spi_cs ? tx[idx] : 1'b0;
         if (spi_mosi !== exp_mosi) m_mosi_err++;
         if (spi_mosi !== prev_mosi && !(prev_sck && !spi_clk) && spi_cs === prev_cs)
            m_edge_err++;
         if (data_rx !== prev_rx && !done) m_rx_unstable++;
         if (pulse_mid && !mid_done && m_rises == 100) begin
            start = 1'b1;
            mid_done = 1;
         end
         if (pulse_gap && !gap_done && m_done_cnt > 0 && busy) begin
            start = 1'b1;
            gap_done = 1;
         end
         if (!busy) break;
         if (cyc >= BUDGET) begin
            m_timeout = 1;
            break;
         end
         prev_sck = spi_clk; prev_cs = spi_cs; prev_mosi = spi_mosi; prev_rx = data_rx;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
   endtask

   task automatic check_frame(input string name, input logic [FB-1:0] exp_rx,
                              input logic [FB-1:0] exp_srx);
      check_int({name, " timeout"}, m_timeout, 0);
      check_int({name, " sck rises"}, m_rises, FB);
      check_int({name, " sck falls"}, m_falls, FB);
      check_int({name, " cs low cycles"}, m_cs_low, CS_LOW_EXP);
      check_int({name, " busy cycles"}, m_busy, BUSY_EXP);
      check_int({name, " done pulses"}, m_done_cnt, 1);
      check_int({name, " done width"}, m_done_max, 1);
      check_int({name, " mosi bit order errs"}, m_mosi_err, 0);
      check_int({name, " mosi off-edge changes"}, m_edge_err, 0);
      check_int({name, " data_rx unstable"}, m_rx_unstable, 0);
      check({name, " master data_rx"}, data_rx, exp_rx);
      check({name, " slave rx"}, s_rx, exp_srx);
   endtask

   // --------------------------------------------------------------------------
   // Frame vector table
   // --------------------------------------------------------------------------
   typedef struct {
      logic [FB-1:0] tx;       // master DATA_TX
      logic [FB-1:0] stx;      // slave transmit frame
      logic [FB-1:0] exp_rx;   // expected master DATA_RX
      logic [FB-1:0] exp_srx;  // expected frame seen by the slave
   } vec_t;

   vec_t vecs [2];

   initial begin
      logic [FB-1:0] lb_tx;
      int            k;
      logic          prev_sck;
      int            rises;

      vecs[0].tx      = {64{8'hA5}};
      vecs[0].stx     = {8{64'h0123456789ABCDEF}};
      vecs[0].exp_rx  = {8{64'h0123456789ABCDEF}};
      vecs[0].exp_srx = {64{8'hA5}};
      vecs[1].tx      = 512'h1;
      vecs[1].stx     = {64{8'h3C}};
      vecs[1].exp_rx  = {64{8'h3C}};
      vecs[1].exp_srx = 512'h1;

      // Reset state
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check_int("reset spi_cs", int'(spi_cs), 1);
      check_int("reset spi_clk", int'(spi_clk), 0);
      check_int("reset spi_mosi", int'(spi_mosi), 0);
      check_int("reset busy", int'(busy), 0);
      check_int("reset done", int'(done), 0);
      check("reset data_rx", data_rx, '0);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);

      // Table-driven frames against the slave model
      for (int i = 0; i < 2; i++) begin
         s_tx = vecs[i].stx;
         run_frame(vecs[i].tx, 1'b0, 1'b0);
         check_frame($sformatf("vec%0d", i), vecs[i].exp_rx, vecs[i].exp_srx);
      end

      // START pulses mid-frame and during GAP are ignored
      s_tx = {16{32'hDEADBEEF}};
      run_frame({16{32'h12345678}}, 1'b1, 1'b1);
      check_frame("busy_start", {16{32'hDEADBEEF}}, {16{32'h12345678}});
      k = 0;
      repeat (40) begin
         @(negedge clk);
         if (!spi_cs || busy || done) k++;
      end
      check_int("no extra frame after ignored starts", k, 0);

      // START held high: back-to-back frames
      s_tx = {64{8'h5A}};
      @(negedge clk);
      data_tx = {64{8'hC3}};
      start   = 1'b1;
      k = 0;
      while (spi_cs && k < 100) begin @(negedge clk); k++; end
      check_int("held start first cs fall seen", int'(spi_cs), 0);
      k = 0;
      while (!spi_cs && k < BUDGET) begin @(negedge clk); k++; end
      check_int("held start first cs rise seen", int'(spi_cs), 1);
      check_int("held start done at cs rise", int'(done), 1);
      check("held start first frame rx", data_rx, {64{8'h5A}});
      k = 0;
      do begin @(negedge clk); k++; end while (spi_cs && k < 100);
      check_int("cs rise to next cs fall", k, CS_GAP + 1);
      start = 1'b0;

      // Reset at bit 200 of the second frame
      rises = 0;
      prev_sck = spi_clk;
      k = 0;
      while (rises < 200 && k < BUDGET) begin
         @(negedge clk);
         k++;
         if (!prev_sck && spi_clk) rises++;
         prev_sck = spi_clk;
      end
      check_int("reached bit 200", rises, 200);
      reset_n = 1'b0;
      @(negedge clk);
      check_int("abort spi_cs", int'(spi_cs), 1);
      check_int("abort spi_clk", int'(spi_clk), 0);
      check_int("abort busy", int'(busy), 0);
      check_int("abort done", int'(done), 0);
      check("abort data_rx", data_rx, '0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      k = 0;
      repeat (30) begin
         @(negedge clk);
         if (done || !spi_cs) k++;
      end
      check_int("no done or cs after abort", k, 0);
      check("data_rx after abort", data_rx, '0);

      // A full frame after the abort
      s_tx = {8{64'hFEDCBA9876543210}};
      run_frame({8{64'h0F1E2D3C4B5A6978}}, 1'b0, 1'b0);
      check_frame("post_abort", {8{64'hFEDCBA9876543210}}, {8{64'h0F1E2D3C4B5A6978}});

`ifdef SPI_MASTER_LOOPBACK_EN
      // Loopback with MISO tied low
      miso_tie0 = 1'b1;
      for (int i = 0; i < FB / 32; i++) lb_tx[i*32 +: 32] = $urandom();
      loopback = 1'b1;
      run_frame(lb_tx, 1'b0, 1'b0);
      loopback = 1'b0;
      check_int("loopback timeout", m_timeout, 0);
      check("loopback data_rx", data_rx, lb_tx);
      loopback = 1'b0;
      run_frame(lb_tx, 1'b0, 1'b0);
      check_int("no-loopback timeout", m_timeout, 0);
      check("no-loopback data_rx", data_rx, '0);
      miso_tie0 = 1'b0;
`else
      lb_tx = '0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
